// File: rtl/jtag_tap_sequencer.sv
// JTAG TAP sequencer: walks a target TAP through an optional IR scan followed by a DR scan,
// shifting latched data LSB first on tdi and capturing tdo into resultVector.
module jtag_tap_sequencer #(
    parameter int MAX_VECTOR_WIDTH = 32,
    parameter int MAX_INSTR_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        instrFlag,
    input  logic [2:0]                  instrWidth,
    input  logic [5:0]                  vectorWidth,
    input  logic [MAX_INSTR_WIDTH-1:0]  instruction,
    input  logic [MAX_VECTOR_WIDTH-1:0] testVector,
    input  logic                        tdo,
    output logic                        tms,
    output logic                        tdi,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [MAX_VECTOR_WIDTH-1:0] resultVector
);

    localparam int VIDX_W = (MAX_VECTOR_WIDTH > 1) ? $clog2(MAX_VECTOR_WIDTH) : 1;
    localparam int IIDX_W = (MAX_INSTR_WIDTH > 1) ? $clog2(MAX_INSTR_WIDTH) : 1;

    typedef enum logic [3:0] {
        TLR_SEQ,
        IDLE,
        LAUNCH,
        SEL_DR,
        SEL_IR,
        CAP_IR,
        SHIFT_IR,
        EXIT1_IR,
        UPD_IR,
        CAP_DR,
        SHIFT_DR,
        EXIT1_DR,
        UPD_DR
    } state_t;

    state_t                      state;
    logic [2:0]                  tlr_cnt;
    logic [5:0]                  bit_cnt;
    logic                        ir_pend;
    logic                        done_q;
    logic                        error_q;
    logic [MAX_VECTOR_WIDTH-1:0] result_q;

    logic [2:0]                  iw_q;
    logic [5:0]                  vw_q;
    logic [MAX_INSTR_WIDTH-1:0]  instr_q;
    logic [MAX_VECTOR_WIDTH-1:0] vec_q;

    logic                        req_legal;
    logic                        accept;
    logic                        ir_last;
    logic                        dr_last;

    function automatic logic legal_vw(input logic [5:0] w);
        return (w == 6'd8) || (w == 6'd16) || (w == 6'd24) || (w == 6'd32);
    endfunction

    function automatic logic legal_iw(input logic [2:0] w);
        return (w == 3'd3) || (w == 3'd4) || (w == 3'd5);
    endfunction

    // The IR width only matters when an IR scan is requested.
    assign req_legal = legal_vw(vectorWidth) && (!instrFlag || legal_iw(instrWidth));
    assign accept    = (state == IDLE) && start && req_legal;
    assign ir_last   = (bit_cnt == ({3'b000, iw_q} - 6'd1));
    assign dr_last   = (bit_cnt == (vw_q - 6'd1));

    // Operation operands are only meaningful after an accepted start, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            iw_q    <= instrWidth;
            vw_q    <= vectorWidth;
            instr_q <= instruction;
            vec_q   <= testVector;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= TLR_SEQ;
            tlr_cnt  <= 3'd0;
            bit_cnt  <= 6'd0;
            ir_pend  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                TLR_SEQ: begin
                    if (tlr_cnt == 3'd4) begin
                        tlr_cnt <= 3'd0;
                        state   <= IDLE;
                    end else begin
                        tlr_cnt <= tlr_cnt + 3'd1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        if (req_legal) begin
                            ir_pend  <= instrFlag;
                            result_q <= '0;
                            state    <= LAUNCH;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                LAUNCH:   state <= SEL_DR;
                SEL_DR:   state <= ir_pend ? SEL_IR : CAP_DR;
                SEL_IR:   state <= CAP_IR;
                CAP_IR: begin
                    bit_cnt <= 6'd0;
                    state   <= SHIFT_IR;
                end
                SHIFT_IR: begin
                    if (ir_last) begin
                        bit_cnt <= 6'd0;
                        state   <= EXIT1_IR;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                EXIT1_IR: state <= UPD_IR;
                UPD_IR: begin
                    ir_pend <= 1'b0;
                    state   <= SEL_DR;
                end
                CAP_DR: begin
                    bit_cnt <= 6'd0;
                    state   <= SHIFT_DR;
                end
                SHIFT_DR: begin
                    result_q[bit_cnt[VIDX_W-1:0]] <= tdo;
                    if (dr_last) begin
                        bit_cnt <= 6'd0;
                        state   <= EXIT1_DR;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                EXIT1_DR: state <= UPD_DR;
                UPD_DR: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default:  state <= TLR_SEQ;
            endcase
        end
    end

    // tms/tdi depend only on registered state, counter and latched operands.
    always_comb begin
        tms = 1'b0;
        tdi = 1'b0;
        case (state)
            TLR_SEQ, LAUNCH, EXIT1_IR, UPD_IR, EXIT1_DR: tms = 1'b1;
            SEL_DR:   tms = ir_pend;
            SHIFT_IR: begin
                tms = ir_last;
                tdi = instr_q[bit_cnt[IIDX_W-1:0]];
            end
            SHIFT_DR: begin
                tms = dr_last;
                tdi = vec_q[bit_cnt[VIDX_W-1:0]];
            end
            default: begin
                tms = 1'b0;
                tdi = 1'b0;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign error        = error_q;
    assign resultVector = result_q;

endmodule

// File: doc/jtag_tap_sequencer.md
JTAG_TAP_SEQUENCER -- requirements
Module: jtag_tap_sequencer

Interface
REQ-001 SHALL have parameter MAX_VECTOR_WIDTH, default 32: width of the testVector and resultVector ports.
REQ-002 SHALL have parameter MAX_INSTR_WIDTH, default 5: width of the instruction port.
REQ-003 clk  input  1  single clock; all state and outputs change on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one scan operation; sampled only in IDLE.
REQ-006 instrFlag  input  1  0 = noInstruction (DR scan only), 1 = yesInstruction (IR scan then DR scan).
REQ-007 instrWidth  input  3  IR length; legal values 3, 4, 5.
REQ-008 vectorWidth  input  6  DR length; legal values 8, 16, 24, 32.
REQ-009 instruction  input  MAX_INSTR_WIDTH  IR opcode; 5'b00000 = bypassRegister, not special-cased.
REQ-010 testVector  input  MAX_VECTOR_WIDTH  DR data shifted out on tdi.
REQ-011 tdo  input  1  serial data from the target TAP.
REQ-012 tms  output  1  TAP mode select to the target.
REQ-013 tdi  output  1  serial data to the target.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at operation completion.
REQ-016 error  output  1  one-cycle pulse when a start is rejected.
REQ-017 resultVector  output  MAX_VECTOR_WIDTH  DR bits captured from tdo.

Function
REQ-018 SHALL implement these states, listed with the tms driven in each: TLR_SEQ(1), IDLE(0), LAUNCH(1), SEL_DR(1 if IR pending, else 0), SEL_IR(0), CAP_IR(0), SHIFT_IR(0; 1 on last bit), EXIT1_IR(1), UPD_IR(1), CAP_DR(0), SHIFT_DR(0; 1 on last bit), EXIT1_DR(1), UPD_DR(0).
REQ-019 tms and tdi SHALL be decoded from registered state and counter only, with no combinational path from any input.
REQ-020 TLR_SEQ SHALL last exactly 5 cycles, counted by a 3-bit counter, then go to IDLE.
REQ-021 In IDLE, a start with legal widths SHALL latch instrFlag, both widths, instruction and testVector, clear resultVector, and go to LAUNCH.
REQ-022 An illegal vectorWidth, or an illegal instrWidth with instrFlag=1, SHALL pulse error for 1 cycle; the block stays in IDLE and nothing is latched.
REQ-023 start while busy=1 SHALL be ignored, with no error pulse.
REQ-024 Transitions: LAUNCH→SEL_DR; SEL_DR→SEL_IR if an IR is pending, else →CAP_DR; SEL_IR→CAP_IR→SHIFT_IR; SHIFT_IR→EXIT1_IR after the last bit; EXIT1_IR→UPD_IR; UPD_IR→SEL_DR with the IR-pending flag cleared; CAP_DR→SHIFT_DR; SHIFT_DR→EXIT1_DR after the last bit; EXIT1_DR→UPD_DR; UPD_DR→IDLE.
REQ-025 Shift states SHALL use a 6-bit bit counter, starting at 0 and ending at width−1; tdi SHALL be the latched data bit at the counter index (LSB first); tdi=0 outside shift states.
REQ-026 In SHIFT_DR, tdo SHALL be sampled every cycle into resultVector[bitCnt]; result bits at width and above SHALL remain 0.
REQ-027 tdo SHALL be ignored in SHIFT_IR.
REQ-028 done SHALL pulse in the first IDLE cycle after UPD_DR.
REQ-029 resultVector SHALL hold its value until the next accepted start.
REQ-030 Latency from the start-accept edge to the done pulse SHALL be W+5 cycles without an IR scan, and I+W+10 cycles with one (I = IR width, W = DR width).
REQ-031 start asserted in the same cycle as the done pulse SHALL be accepted.

Reset
REQ-032 reset=0 SHALL immediately force state to TLR_SEQ and set tms=1, tdi=0, busy=1, done=0, error=0, resultVector=0, and all counters and flags to 0; this holds in any state, including mid-shift.
REQ-033 After reset deasserts, the block SHALL run the full 5-cycle TLR_SEQ before reaching IDLE.
REQ-034 While reset is asserted, start SHALL be ignored.

Verification
REQ-035 Reset release: 5 cycles tms=1, busy=1 -> then tms=0, busy=0, resultVector=0.
REQ-036 instrFlag=0, vectorWidth=8, testVector=0xA5, tdo fed 0x3C LSB first -> tms=1,0,0,0×7,1,1,0; tdi=1,0,1,0,0,1,0,1 in SHIFT_DR; done at +13 cycles; resultVector=0x0000003C.
REQ-037 instrFlag=1, instrWidth=5, instruction=0x00, vectorWidth=32, testVector=0xDEADBEEF, tdo tied to tdi -> done at +47 cycles; resultVector=0xDEADBEEF; tdi=0 for all 5 SHIFT_IR cycles.
REQ-038 vectorWidth=12, then instrFlag=1 with instrWidth=6 -> one error pulse each; busy stays 0; resultVector unchanged.
REQ-039 reset asserted in cycle 4 of SHIFT_DR -> tms=1 and resultVector=0 the same cycle; after release, 5 TLR cycles then IDLE; no done pulse.
REQ-040 start pulses during busy, and start held high across the done cycle -> mid-operation pulses ignored; a new operation launches in the done cycle.
